seq_checker: RTL
================

SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 4: consecutive in-sequence beats needed to enter LOCKED (range 2..15).
REQ-002 Parameter LOSS_COUNT, default 3: consecutive mismatching beats in LOCKED that force return to HUNT (range 1..15).
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 data_in  input  8  received data byte, sampled only when data_valid=1.
REQ-006 data_valid  input  1  data_in qualifier; no backpressure, every valid beat is consumed.
REQ-007 err_clr  input  1  synchronous clear of err_count.
REQ-008 match  output  1  registered; 1 when locked and last valid beat equalled expected value; feeds the downstream consecutive-mismatch monitor.
REQ-009 locked  output  1  registered; 1 while FSM is in LOCKED.
REQ-010 err_count  output  16  registered count of mismatching beats in LOCKED.

Function
REQ-011 The block SHALL predict the next byte with next(x); the sequence type is set by the macro in Configuration.
REQ-012 The FSM SHALL have two states, HUNT and LOCKED, plus internal run counter (4 bits) and expected register (8 bits).
REQ-013 Cycles with data_valid=0 SHALL leave state, counters, expected, match and locked unchanged.
REQ-014 HUNT, valid beat, run=0 or data_in!=expected: expected<=next(data_in), run<=1; match stays 0.
REQ-015 HUNT, valid beat, run>0 and data_in==expected: expected<=next(data_in), run<=run+1; if run+1==LOCK_COUNT then state<=LOCKED, locked<=1, match<=1, run<=0.
REQ-016 LOCKED, valid beat, data_in==expected: match<=1, run<=0, expected<=next(expected).
REQ-017 LOCKED, valid beat, data_in!=expected: match<=0, err_count<=err_count+1 saturating at 0xFFFF, expected<=next(expected), run<=run+1.
REQ-018 LOCKED mismatch with run+1==LOSS_COUNT: state<=HUNT, locked<=0, match<=0, run<=0 on that same edge.
REQ-019 Latency: match/locked/err_count reflect a valid beat on the clock edge that samples it (visible the following cycle).
REQ-020 err_clr=1 SHALL set err_count to 0 on the next edge; err_clr simultaneous with a counted mismatch -> err_count=0 (clear wins).
REQ-021 err_count SHALL be preserved across HUNT/LOCKED transitions; only rst or err_clr clears it.
REQ-022 Wrap-around: counter-mode next(0xFF)=0x00 with no special handling.

Reset
REQ-023 rst=1 SHALL on the next edge force state=HUNT, run=0, expected=0x00, match=0, locked=0, err_count=0, overriding all other inputs including mid-lock.
REQ-024 After rst deasserts, the first valid beat SHALL be treated as a HUNT seed (REQ-014).

Configuration
REQ-025 Macro SEQ_CHECKER_PRBS_EN defined: next(x)={x[6:0], x[7]^x[5]^x[4]^x[3]} (PRBS-8); in HUNT a data_in of 0x00 SHALL set run<=0 and not seed (lock-up value rejected).
REQ-026 Macro SEQ_CHECKER_PRBS_EN undefined: next(x)=x+1 modulo 256 (incrementing counter); 0x00 is a legal seed.

Verification
REQ-027 Counter mode, LOCK_COUNT=4: valid beats 0x10,0x11,0x12,0x13 -> locked=1, match=1 after 4th beat; after 3rd beat locked=0.
REQ-028 Counter mode locked at expected 0x20: beats 0x20,0x55,0x22 -> match 1,0,1; err_count=1; locked stays 1.
REQ-029 Counter mode locked, LOSS_COUNT=3: three consecutive wrong beats -> locked=0, match=0 after 3rd; err_count=3; then 0x40..0x43 relocks.
REQ-030 Counter mode: beats 0xFE,0xFF,0x00,0x01 -> lock achieved across wrap; data_valid low for 5 cycles between beats leaves match/locked unchanged.
REQ-031 PRBS build: seed 0x00 then valid PRBS run of 4 from 0x01 -> 0x00 ignored, lock after 4th PRBS beat; err_clr with concurrent mismatch -> err_count=0.
REQ-032 rst asserted 1 cycle while locked with err_count=5 -> next cycle locked=0, match=0, err_count=0, state HUNT.

Source files
------------

// File: rtl/seq_checker.sv
// seq_checker: locks onto a predictable byte stream and counts errors.
//
// The block predicts each incoming byte from the previous one. It starts in
// HUNT and moves to LOCKED after LOCK_COUNT consecutive in-sequence beats.
// In LOCKED it compares every valid beat with the prediction, counts the
// mismatches, and falls back to HUNT after LOSS_COUNT consecutive mismatches.
//
// Build option:
//   SEQ_CHECKER_PRBS_EN  defined   : PRBS-8, next(x) = {x[6:0], x7^x5^x4^x3}.
//                                    In HUNT, a 0x00 beat (the lock-up value)
//                                    clears the run and is not used as a seed.
//                        undefined : incrementing counter, next(x) = x+1 mod 256.
//
// Parameters:
//   LOCK_COUNT  consecutive in-sequence beats needed to lock (2..15)
//   LOSS_COUNT  consecutive mismatches in LOCKED that drop the lock (1..15)
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   data_in     received byte, used only when data_valid=1
//   data_valid  qualifies data_in; every valid beat is consumed
//   err_clr     synchronous clear of err_count (wins over a same-cycle count)
//   match       registered: locked and the last valid beat was as predicted
//   locked      registered: FSM is in LOCKED
//   err_count   registered saturating count of mismatches seen in LOCKED
module seq_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  input  logic        err_clr,
  output logic        match,
  output logic        locked,
  output logic [15:0] err_count
);

  localparam logic [4:0] LOCK_C = 5'(LOCK_COUNT);
  localparam logic [4:0] LOSS_C = 5'(LOSS_COUNT);

`ifdef SEQ_CHECKER_PRBS_EN
  localparam logic ZERO_REJECT = 1'b1;
`else
  localparam logic ZERO_REJECT = 1'b0;
`endif

  function automatic logic [7:0] next_val(input logic [7:0] x);
`ifdef SEQ_CHECKER_PRBS_EN
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
`else
    return x + 8'd1;
`endif
  endfunction

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [3:0]  run, run_nxt;
  logic [7:0]  expected, expected_nxt;
  logic        match_nxt;
  logic [15:0] err_nxt;
  logic [4:0]  run_inc;
  logic        hit;

  assign run_inc = {1'b0, run} + 5'd1;
  assign hit     = (data_in == expected);

  // State register (plus the datapath registers that move with it)
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      run       <= 4'd0;
      expected  <= 8'h00;
      match     <= 1'b0;
      err_count <= 16'd0;
    end else begin
      state     <= state_nxt;
      run       <= run_nxt;
      expected  <= expected_nxt;
      match     <= match_nxt;
      err_count <= err_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    run_nxt      = run;
    expected_nxt = expected;
    match_nxt    = match;
    err_nxt      = err_count;

    if (data_valid) begin
      case (state)
        HUNT: begin
          match_nxt = 1'b0;
          if (ZERO_REJECT && data_in == 8'h00) begin
            // lock-up value of the PRBS: restart the search, keep no seed
            run_nxt = 4'd0;
          end else if (run == 4'd0 || !hit) begin
            expected_nxt = next_val(data_in);
            run_nxt      = 4'd1;
          end else begin
            expected_nxt = next_val(data_in);
            if (run_inc == LOCK_C) begin
              state_nxt = LOCKED;
              match_nxt = 1'b1;
              run_nxt   = 4'd0;
            end else begin
              run_nxt = run_inc[3:0];
            end
          end
        end
        LOCKED: begin
          // prediction free-runs from the expected value, not from data_in
          expected_nxt = next_val(expected);
          if (hit) begin
            match_nxt = 1'b1;
            run_nxt   = 4'd0;
          end else begin
            match_nxt = 1'b0;
            if (err_count != 16'hFFFF) err_nxt = err_count + 16'd1;
            if (run_inc == LOSS_C) begin
              state_nxt = HUNT;
              run_nxt   = 4'd0;
            end else begin
              run_nxt = run_inc[3:0];
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end

    if (err_clr) err_nxt = 16'd0;
  end

  // Output logic: locked is a decode of the state flop
  always_comb begin
    locked = (state == LOCKED);
  end

endmodule
